// File: rtl/ula_seq.sv
// ula_seq: registered multi-cycle ALU with a START/BUSY/DONE handshake.
// Single-cycle AND/OR/ADD/SLT/XOR and an iterative shift-add unsigned MUL.
// RESULT and the flags load only on the completion edge and hold otherwise.
module ula_seq #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             AIN,
  input  logic             BIN,
  input  logic             CIN,
  input  logic [2:0]       OPERATION,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             OVERFLOW,
  output logic             ZERO
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EXEC = 1'b1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  logic [0:0]         r_state;
  logic [CNTW-1:0]    r_cnt;
  logic [2:0]         r_op;
  logic               r_cin;
  logic [2*WIDTH-1:0] r_acc;
  // Multiplicand/multiplier registers double as the latched a/b operands:
  // non-MUL ops finish on the first EXEC edge, before any shift happens.
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;

  logic [WIDTH-1:0]   w_a_in, w_b_in, w_a, w_b;
  logic [WIDTH:0]     w_sum;
  logic               w_cmsb, w_ovf_add, w_less, w_done;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_res;
  logic               w_cout, w_ovf;

  assign w_a_in    = AIN ? ~A : A;
  assign w_b_in    = BIN ? ~B : B;
  assign w_a       = r_mcand[WIDTH-1:0];
  assign w_b       = r_mplr;
  assign w_sum     = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, r_cin};
  // Carry into the MSB recovered from the MSB sum bit and its operands.
  assign w_cmsb    = w_a[WIDTH-1] ^ w_b[WIDTH-1] ^ w_sum[WIDTH-1];
  assign w_ovf_add = w_cmsb ^ w_sum[WIDTH];
  assign w_less    = w_sum[WIDTH-1] ^ w_ovf_add;
  assign w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign w_done    = (r_state == S_EXEC) && (r_cnt == CNTW'(1));

  // Result/flag selection presented to the output registers at completion.
  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    case (r_op)
      OP_AND: w_res = w_a & w_b;
      OP_OR:  w_res = w_a | w_b;
      OP_XOR: w_res = w_a ^ w_b;
      OP_ADD: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = w_ovf_add;
      end
      OP_SLT: begin
        w_res  = {{(WIDTH-1){1'b0}}, w_less};
        w_cout = w_sum[WIDTH];
        w_ovf  = w_ovf_add;
      end
      OP_MUL: begin
        w_res = w_acc_nxt[WIDTH-1:0];
        w_ovf = |w_acc_nxt[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // Control FSM, operand latch, shift-add datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_cin    <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplr   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      RESULT   <= '0;
      COUT     <= 1'b0;
      OVERFLOW <= 1'b0;
      ZERO     <= 1'b1;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state <= S_EXEC;
            BUSY    <= 1'b1;
            r_op    <= OPERATION;
            r_cin   <= CIN;
            r_acc   <= '0;
            r_mcand <= {{WIDTH{1'b0}}, w_a_in};
            r_mplr  <= w_b_in;
            r_cnt   <= (OPERATION == OP_MUL) ? CNTW'(WIDTH) : CNTW'(1);
          end
        end
        default: begin
          r_acc   <= w_acc_nxt;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt - CNTW'(1);
          if (w_done) begin
            r_state  <= S_IDLE;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            RESULT   <= w_res;
            COUT     <= w_cout;
            OVERFLOW <= w_ovf;
            ZERO     <= ~|w_res;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (WIDTH=8): table vectors plus a reference
// model, expected results queued at issue and compared when DONE pulses.
module tb_ula_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0, AIN = 1'b0, BIN = 1'b0, CIN = 1'b0;
  logic [2:0] OPERATION = '0;
  logic [7:0] A = '0, B = '0;
  logic       BUSY, DONE, COUT, OVERFLOW, ZERO;
  logic [7:0] RESULT;

  ula_seq #(.WIDTH(8), .CNTW(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .AIN(AIN), .BIN(BIN), .CIN(CIN),
    .OPERATION(OPERATION), .A(A), .B(B), .BUSY(BUSY), .DONE(DONE),
    .RESULT(RESULT), .COUT(COUT), .OVERFLOW(OVERFLOW), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic       ain, bin, cin;
    logic [7:0] res;
    logic       cout, ovf, zero;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       cout, ovf, zero;
    int         done_cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, b,
                              input logic ain, bin, cin,
                              input logic [7:0] res, input logic cout, ovf, zero);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.ain = ain; v.bin = bin; v.cin = cin;
    v.res = res; v.cout = cout; v.ovf = ovf; v.zero = zero;
    return v;
  endfunction

  // Reference model in plain integer arithmetic; signed overflow and SLT come
  // from the exact signed sum rather than carry bits.
  function automatic vec_t model(input logic [2:0] op, input logic [7:0] a, b,
                                 input logic ain, bin, cin);
    vec_t v;
    logic [7:0] ea, eb;
    int s, ss, p;
    v = mk(op, a, b, ain, bin, cin, 8'h00, 1'b0, 1'b0, 1'b0);
    ea = ain ? ~a : a;
    eb = bin ? ~b : b;
    s  = int'(ea) + int'(eb) + int'(cin);
    ss = int'($signed(ea)) + int'($signed(eb)) + int'(cin);
    p  = int'(ea) * int'(eb);
    case (op)
      3'd0: v.res = ea & eb;
      3'd1: v.res = ea | eb;
      3'd5: v.res = ea ^ eb;
      3'd2, 3'd3: begin
        v.cout = (s > 255);
        v.ovf  = (ss > 127) || (ss < -128);
        v.res  = (op == 3'd2) ? 8'(s) : {7'd0, ss < 0};
      end
      3'd4: begin
        v.res = 8'(p);
        v.ovf = (p > 255);
      end
      default: v.res = 8'h00;
    endcase
    v.zero = (v.res == 8'h00);
    return v;
  endfunction

  // Drive one request in the current cycle and queue its expectation.
  task automatic issue(input string name, input vec_t v);
    exp_t e;
    OPERATION = v.op; A = v.a; B = v.b; AIN = v.ain; BIN = v.bin; CIN = v.cin;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk({name, "_busy"}, BUSY, 1);
    e.name = name; e.res = v.res; e.cout = v.cout; e.ovf = v.ovf; e.zero = v.zero;
    e.done_cyc = cyc + ((v.op == 3'd4) ? 8 : 1);
    q.push_back(e);
  endtask

  // Returns in the DONE cycle (just after the falling edge) or flags a timeout.
  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge CLK); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout actual=pending%0d expected=pending0", q.size());
      q.delete();
    end
  endtask

  // Scoreboard: every DONE pulse must match the oldest outstanding request.
  always @(negedge CLK) begin
    if (DONE) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_done actual=DONE1 expected=DONE0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_result"}, RESULT, e.res);
        chk({e.name, "_cout"}, COUT, e.cout);
        chk({e.name, "_ovf"}, OVERFLOW, e.ovf);
        chk({e.name, "_zero"}, ZERO, e.zero);
        chk({e.name, "_latency"}, cyc, e.done_cyc);
        chk({e.name, "_busy_low"}, BUSY, 0);
      end
    end
  end

  vec_t tbl[10];

  initial begin
    tbl[0] = mk(3'd2, 8'h7F, 8'h01, 0, 0, 0, 8'h80, 0, 1, 0); // ADD overflow
    tbl[1] = mk(3'd2, 8'h05, 8'h05, 0, 1, 1, 8'h00, 1, 0, 1); // SUB to zero
    tbl[2] = mk(3'd3, 8'h80, 8'h01, 0, 1, 1, 8'h01, 1, 1, 0); // SLT -128<1
    tbl[3] = mk(3'd4, 8'd13, 8'd11, 0, 0, 0, 8'h8F, 0, 0, 0); // MUL
    tbl[4] = mk(3'd4, 8'h20, 8'h10, 0, 0, 0, 8'h00, 0, 1, 1); // MUL overflow
    tbl[5] = mk(3'd0, 8'hF0, 8'h3C, 1, 0, 0, 8'h0C, 0, 0, 0); // AND, ~A
    tbl[6] = mk(3'd5, 8'hAA, 8'hFF, 0, 0, 0, 8'h55, 0, 0, 0); // XOR
    tbl[7] = mk(3'd7, 8'hFF, 8'hFF, 0, 0, 1, 8'h00, 0, 0, 1); // reserved
    tbl[8] = mk(3'd1, 8'h12, 8'h40, 0, 0, 0, 8'h52, 0, 0, 0); // OR
    tbl[9] = mk(3'd6, 8'h7F, 8'h7F, 1, 1, 1, 8'h00, 0, 0, 1); // reserved

    repeat (2) @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_cout", COUT, 0);
    chk("rst_ovf", OVERFLOW, 0);
    chk("rst_zero", ZERO, 1);
    RST = 1'b0;
    @(negedge CLK);

    // Table vectors; each issue lands in the previous op's DONE cycle.
    for (int i = 0; i < 10; i++) begin
      issue($sformatf("vec%0d", i), tbl[i]);
      wait_done();
    end

    // Random vectors against the model.
    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v = model(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom));
      issue($sformatf("rnd%0d", i), v);
      wait_done();
    end

    // START during a MUL is ignored; the queued MUL must be the only DONE.
    issue("mul_ign", mk(3'd4, 8'd13, 8'd11, 0, 0, 0, 8'h8F, 0, 0, 0));
    repeat (2) @(posedge CLK);
    #1;
    OPERATION = 3'd2; A = 8'h01; B = 8'h01; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done();
    issue("add_in_done", model(3'd2, 8'h30, 8'h05, 0, 0, 0));
    wait_done();
    repeat (12) @(negedge CLK);
    chk("hold_result", RESULT, 8'h35);
    chk("hold_busy", BUSY, 0);

    // Asynchronous abort at t0+4 of a MUL.
    issue("mul_abort", model(3'd4, 8'hFF, 8'hFF, 0, 0, 0));
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_result", RESULT, 0);
    chk("abort_zero", ZERO, 1);
    q.delete();
    @(negedge CLK);
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    #1;
    issue("add_after_rst", mk(3'd2, 8'h01, 8'h02, 0, 0, 0, 8'h03, 0, 0, 0));
    wait_done();
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
